// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared types and constants for the AES-CTR keystream engine
package aes_ctr_pkg;

   // Default width of the incrementing counter field (low bits of the counter block)
   localparam int CTR_W_DEF     = 32;

   // 32-bit words carried by one 128-bit keystream block
   localparam int WORDS_PER_BLK = 4;

   // Engine control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      WAIT = 2'd2,
      XOR  = 2'd3
   } state_t;

endpackage

// File: rtl/aes_ctr_engine.sv
// rtl/aes_ctr_engine.sv - AES-CTR stream engine: counter blocks out to an AES core, keystream XOR on a 32-bit stream
module aes_ctr_engine
   import aes_ctr_pkg::*;
#(
   parameter int CTR_W = CTR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,

   input  logic [127-CTR_W:0] cfg_nonce,
   input  logic [CTR_W-1:0]   cfg_ctr_init,
   input  logic               start,
   input  logic               abort,

   input  logic [31:0]        s_data,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,

   output logic [31:0]        m_data,
   output logic               m_valid,
   output logic               m_last,
   input  logic               m_ready,

   output logic [127:0]       core_plaintext,
   output logic               core_start,
   input  logic               core_ready,
   input  logic               core_done,
   input  logic [127:0]       core_ciphertext,

   output logic               busy,
   output logic               ctr_wrap,
   output logic [31:0]        blk_count
);

   localparam logic [1:0]       LAST_IDX = 2'(WORDS_PER_BLK - 1);
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

   state_t               state;
   logic [CTR_W-1:0]     ctr;
   logic [127-CTR_W:0]   nonce;
   logic [127:0]         ks_reg;
   logic [1:0]           idx;
   // Set when an abort leaves an encryption in flight; its core_done must not be used
   logic                 done_discard;

   logic [31:0]          ks_word;
   logic [CTR_W-1:0]     ctr_inc;
   logic                 in_fire;

   assign busy    = (state != IDLE);
   assign s_ready = (state == XOR) && (!m_valid || m_ready);
   assign in_fire = s_valid && s_ready;
   assign ctr_inc = ctr + CTR_ONE;

   // Select the keystream word for the current index, most significant word first
   always_comb begin
      ks_word = 32'd0;
      case (idx)
         2'd0:    ks_word = ks_reg[127:96];
         2'd1:    ks_word = ks_reg[95:64];
         2'd2:    ks_word = ks_reg[63:32];
         default: ks_word = ks_reg[31:0];
      endcase
   end

   // Control FSM with counter, keystream register and registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ctr            <= '0;
         nonce          <= '0;
         ks_reg         <= '0;
         idx            <= 2'd0;
         done_discard   <= 1'b0;
         blk_count      <= 32'd0;
         ctr_wrap       <= 1'b0;
         m_data         <= 32'd0;
         m_valid        <= 1'b0;
         m_last         <= 1'b0;
         core_start     <= 1'b0;
         core_plaintext <= 128'd0;
      end else if (abort) begin
         // Abort wins over everything; ctr_wrap and blk_count are left as they are
         state        <= IDLE;
         m_valid      <= 1'b0;
         ks_reg       <= '0;
         idx          <= 2'd0;
         core_start   <= 1'b0;
         if ((state == GEN) || (state == WAIT)) begin
            done_discard <= 1'b1;
         end
      end else begin
         core_start <= 1'b0;

         // A word already presented drains independently of the state
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         // The in-flight result of an aborted block is dropped whatever the state
         if (core_done && done_discard) begin
            done_discard <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start && core_ready) begin
                  ctr            <= cfg_ctr_init;
                  nonce          <= cfg_nonce;
                  blk_count      <= 32'd0;
                  ctr_wrap       <= 1'b0;
                  core_plaintext <= {cfg_nonce, cfg_ctr_init};
                  core_start     <= 1'b1;
                  state          <= GEN;
               end
            end

            GEN: begin
               // core_start was raised on entry, so it lasts exactly this cycle
               state <= WAIT;
            end

            WAIT: begin
               if (core_done && !done_discard) begin
                  ks_reg <= core_ciphertext;
                  idx    <= 2'd0;
                  state  <= XOR;
               end
            end

            XOR: begin
               if (in_fire) begin
                  m_data  <= s_data ^ ks_word;
                  m_valid <= 1'b1;
                  m_last  <= s_last;
                  idx     <= idx + 2'd1;
                  if (s_last) begin
                     blk_count <= blk_count + 32'd1;
                     ks_reg    <= '0;
                     idx       <= 2'd0;
                     state     <= IDLE;
                  end else if (idx == LAST_IDX) begin
                     blk_count <= blk_count + 32'd1;
                     if (&ctr) begin
                        // Counter exhausted: stop rather than reuse keystream
                        ctr_wrap <= 1'b1;
                        ks_reg   <= '0;
                        idx      <= 2'd0;
                        state    <= IDLE;
                     end else begin
                        ctr            <= ctr_inc;
                        core_plaintext <= {nonce, ctr_inc};
                        core_start     <= 1'b1;
                        state          <= GEN;
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_ctr_engine.sv
// tb/tb_aes_ctr_engine.sv - directed-vector bench for aes_ctr_engine with a table-driven AES core model
module tb_aes_ctr_engine;
   import aes_ctr_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [95:0]  cfg_nonce;
   logic [31:0]  cfg_ctr_init;
   logic         start, abort;
   logic [31:0]  s_data;
   logic         s_valid, s_last, s_ready;
   logic [31:0]  m_data;
   logic         m_valid, m_last, m_ready;
   logic [127:0] core_plaintext;
   logic         core_start, core_ready, core_done;
   logic [127:0] core_ciphertext;
   logic         busy, ctr_wrap;
   logic [31:0]  blk_count;

   int n_vec  = 0;
   int n_fail = 0;

   localparam logic [95:0] F55_NONCE = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
   localparam logic [31:0] F55_CTR   = 32'hfcfdfeff;

   always #5 clk = ~clk;

   aes_ctr_engine #(.CTR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_nonce(cfg_nonce), .cfg_ctr_init(cfg_ctr_init), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .core_plaintext(core_plaintext), .core_start(core_start), .core_ready(core_ready),
      .core_done(core_done), .core_ciphertext(core_ciphertext),
      .busy(busy), .ctr_wrap(ctr_wrap), .blk_count(blk_count)
   );

   // AES-256 core stand-in, key 603deb10...0914dff4 assumed loaded: known SP800-38A
   // counter blocks return their published keystream, other blocks a fixed mix
   function automatic logic [127:0] ks_of(input logic [127:0] pt);
      if (pt == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff)
         return 128'h0bdf7df1591716335e9a8b15c860c502;
      else if (pt == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00)
         return 128'h5a6e699d536119065433863c8f657b94;
      else
         return {pt[63:0], pt[127:64]} ^ {4{32'h5a5ac3c3}};
   endfunction

   logic         core_ready_en;
   logic         pending;
   int           delay;
   logic [127:0] pt_lat;
   logic [127:0] pt_log[$];

   assign core_ready = core_ready_en && !pending;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending         <= 1'b0;
         core_done       <= 1'b0;
         core_ciphertext <= 128'd0;
         delay           <= 0;
         pt_lat          <= 128'd0;
      end else begin
         core_done <= 1'b0;
         if (core_start && !pending) begin
            pending <= 1'b1;
            delay   <= 3;
            pt_lat  <= core_plaintext;
            pt_log.push_back(core_plaintext);
         end else if (pending) begin
            if (delay == 0) begin
               pending         <= 1'b0;
               core_done       <= 1'b1;
               core_ciphertext <= ks_of(pt_lat);
            end else begin
               delay <= delay - 1;
            end
         end
      end
   end

   logic [31:0] in_w[$];
   logic        in_l[$];
   logic [31:0] out_w[$];
   logic        out_l[$];
   int          stable_viol;
   int          acc_cnt;

   task automatic do_start(input logic [95:0] n, input logic [31:0] c);
      @(negedge clk);
      cfg_nonce = n; cfg_ctr_init = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_f55(input int nwords);
      logic [31:0] w[8] = '{32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a,
                            32'hae2d8a57, 32'h1e03ac9c, 32'h9eb76fac, 32'h45af8e51};
      in_w.delete(); in_l.delete();
      for (int i = 0; i < nwords; i++) begin
         in_w.push_back(w[i]);
         in_l.push_back(i == nwords - 1);
      end
   endtask

   task automatic run_stream(input bit bp, input int budget);
      int          widx = 0;
      bit          hold = 1'b0;
      logic [31:0] hold_d = 32'd0;
      bit          done = 1'b0;
      out_w.delete(); out_l.delete(); stable_viol = 0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (widx < in_w.size()) begin
            s_valid = 1'b1; s_data = in_w[widx]; s_last = in_l[widx];
         end else begin
            s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
         end
         m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (hold && (!m_valid || m_data !== hold_d)) stable_viol++;
         hold   = m_valid && !m_ready;
         hold_d = m_data;
         if (m_valid && m_ready) begin
            out_w.push_back(m_data); out_l.push_back(m_last);
         end
         if (s_valid && s_ready) widx++;
         if (!busy && !m_valid) done = 1'b1;
      end
      acc_cnt = widx;
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
      if (!done) begin
         n_vec++; n_fail++;
         $display("FAIL stream_timeout: engine still busy after %0d cycles, required idle", budget);
      end
   endtask

   task automatic test_reset;
      n_vec++; if (m_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_m_valid: got %b expected 0", m_valid); end
      n_vec++; if (m_data !== 32'd0)        begin n_fail++; $display("FAIL rst_m_data: got %h expected 0", m_data); end
      n_vec++; if (s_ready !== 1'b0)        begin n_fail++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
      n_vec++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_vec++; if (ctr_wrap !== 1'b0)       begin n_fail++; $display("FAIL rst_ctr_wrap: got %b expected 0", ctr_wrap); end
      n_vec++; if (blk_count !== 32'd0)     begin n_fail++; $display("FAIL rst_blk_count: got %0d expected 0", blk_count); end
      n_vec++; if (core_start !== 1'b0)     begin n_fail++; $display("FAIL rst_core_start: got %b expected 0", core_start); end
      n_vec++; if (core_plaintext !== 128'd0) begin n_fail++; $display("FAIL rst_core_pt: got %h expected 0", core_plaintext); end
   endtask

   task automatic test_start_ignored;
      core_ready_en = 1'b0;
      do_start(F55_NONCE, F55_CTR);
      #1;
      n_vec++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL start_nr_busy: got %b expected 0", busy); end
      n_vec++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL start_nr_core_start: got %b expected 0", core_start); end
      core_ready_en = 1'b1;
   endtask

   task automatic test_one_block;
      logic [31:0] e[4] = '{32'h601ec313, 32'h775789a5, 32'hb7a7f504, 32'hbbf3d228};
      load_f55(4);
      do_start(F55_NONCE, F55_CTR);
      run_stream(1'b0, 60);
      n_vec++; if (out_w.size() !== 4) begin n_fail++; $display("FAIL blk1_count: got %0d words expected 4", out_w.size()); end
      for (int i = 0; i < 4 && i < out_w.size(); i++) begin
         n_vec++;
         if (out_w[i] !== e[i] || out_l[i] !== (i == 3)) begin
            n_fail++; $display("FAIL blk1_word%0d: got %h last %b expected %h last %b", i, out_w[i], out_l[i], e[i], (i == 3));
         end
      end
      n_vec++; if (blk_count !== 32'd1) begin n_fail++; $display("FAIL blk1_blk_count: got %0d expected 1", blk_count); end
   endtask

   task automatic check_two_block_out(input string tag);
      logic [31:0] e[8] = '{32'h601ec313, 32'h775789a5, 32'hb7a7f504, 32'hbbf3d228,
                            32'hf443e3ca, 32'h4d62b59a, 32'hca84e990, 32'hcacaf5c5};
      n_vec++; if (out_w.size() !== 8) begin n_fail++; $display("FAIL %s_count: got %0d words expected 8", tag, out_w.size()); end
      for (int i = 0; i < 8 && i < out_w.size(); i++) begin
         n_vec++;
         if (out_w[i] !== e[i] || out_l[i] !== (i == 7)) begin
            n_fail++; $display("FAIL %s_word%0d: got %h last %b expected %h last %b", tag, i, out_w[i], out_l[i], e[i], (i == 7));
         end
      end
      n_vec++; if (blk_count !== 32'd2) begin n_fail++; $display("FAIL %s_blk_count: got %0d expected 2", tag, blk_count); end
   endtask

   task automatic test_two_blocks;
      int sz = pt_log.size();
      load_f55(8);
      do_start(F55_NONCE, F55_CTR);
      run_stream(1'b0, 80);
      check_two_block_out("blk2");
      n_vec++;
      if (pt_log.size() - sz !== 2) begin
         n_fail++; $display("FAIL blk2_core_starts: got %0d expected 2", pt_log.size() - sz);
      end else if (pt_log[sz+1][31:0] !== 32'hfcfdff00) begin
         n_fail++; $display("FAIL blk2_ctr_word: got %h expected fcfdff00", pt_log[sz+1][31:0]);
      end
   endtask

   task automatic test_backpressure;
      load_f55(8);
      do_start(F55_NONCE, F55_CTR);
      run_stream(1'b1, 300);
      check_two_block_out("bp");
      n_vec++; if (stable_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations expected 0", stable_viol); end
   endtask

   task automatic test_wrap;
      logic [127:0] ks = ks_of({F55_NONCE, 32'hffffffff});
      logic [31:0]  ex;
      int           sz = pt_log.size();
      int           rdy_seen = 0;
      in_w.delete(); in_l.delete();
      for (int i = 0; i < 8; i++) begin
         in_w.push_back(32'h10203040 + 32'(i) * 32'h01020304);
         in_l.push_back(i == 7);
      end
      do_start(F55_NONCE, 32'hffffffff);
      run_stream(1'b0, 60);
      n_vec++; if (out_w.size() !== 4) begin n_fail++; $display("FAIL wrap_count: got %0d words expected 4", out_w.size()); end
      for (int i = 0; i < 4 && i < out_w.size(); i++) begin
         ex = in_w[i] ^ ks[127 - 32*i -: 32];
         n_vec++; if (out_w[i] !== ex) begin n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", i, out_w[i], ex); end
      end
      n_vec++; if (ctr_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_flag: got %b expected 1", ctr_wrap); end
      n_vec++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL wrap_busy: got %b expected 0", busy); end
      n_vec++; if (acc_cnt !== 4)     begin n_fail++; $display("FAIL wrap_accepted: got %0d expected 4", acc_cnt); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = in_w[4]; s_last = 1'b0;
         #1;
         if (s_ready) rdy_seen++;
      end
      s_valid = 1'b0;
      n_vec++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL wrap_s_ready: got %0d ready cycles expected 0", rdy_seen); end
      n_vec++; if (pt_log.size() - sz !== 1) begin n_fail++; $display("FAIL wrap_core_starts: got %0d expected 1", pt_log.size() - sz); end
   endtask

   task automatic test_abort;
      logic [31:0] e[4] = '{32'h601ec313, 32'h775789a5, 32'hb7a7f504, 32'hbbf3d228};
      do_start(F55_NONCE, F55_CTR);
      #1;
      n_vec++; if (ctr_wrap !== 1'b0) begin n_fail++; $display("FAIL abort_wrap_clear: got %b expected 0", ctr_wrap); end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      n_vec++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      n_vec++; if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL abort_m_valid: got %b expected 0", m_valid); end
      n_vec++; if (dut.ks_reg !== 128'd0) begin n_fail++; $display("FAIL abort_ks: got %h expected 0", dut.ks_reg); end
      for (int c = 0; c < 20 && pending; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      #1;
      n_vec++; if (busy !== 1'b0 || dut.ks_reg !== 128'd0) begin
         n_fail++; $display("FAIL abort_late_done: got busy %b ks %h expected busy 0 ks 0", busy, dut.ks_reg);
      end
      load_f55(4);
      do_start(F55_NONCE, F55_CTR);
      run_stream(1'b0, 60);
      n_vec++; if (out_w.size() !== 4) begin n_fail++; $display("FAIL abort_rerun_count: got %0d words expected 4", out_w.size()); end
      for (int i = 0; i < 4 && i < out_w.size(); i++) begin
         n_vec++; if (out_w[i] !== e[i]) begin n_fail++; $display("FAIL abort_rerun_word%0d: got %h expected %h", i, out_w[i], e[i]); end
      end
   endtask

   task automatic test_slast_and_reset;
      int sz;
      bit got_ready = 1'b0;
      load_f55(2);
      do_start(F55_NONCE, F55_CTR);
      run_stream(1'b0, 60);
      n_vec++; if (out_w.size() !== 2) begin n_fail++; $display("FAIL slast_count: got %0d words expected 2", out_w.size()); end
      if (out_w.size() == 2) begin
         n_vec++; if (out_w[1] !== 32'h775789a5 || out_l[1] !== 1'b1 || out_l[0] !== 1'b0) begin
            n_fail++; $display("FAIL slast_word1: got %h last %b expected 775789a5 last 1", out_w[1], out_l[1]);
         end
      end
      n_vec++; if (blk_count !== 32'd1) begin n_fail++; $display("FAIL slast_blk_count: got %0d expected 1", blk_count); end
      n_vec++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL slast_busy: got %b expected 0", busy); end

      do_start(F55_NONCE, F55_CTR);
      s_valid = 1'b1; s_data = 32'h6bc1bee2; s_last = 1'b0; m_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (s_ready) begin got_ready = 1'b1; break; end
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      n_vec++; if (!got_ready || m_valid !== 1'b1 || m_data !== 32'h601ec313) begin
         n_fail++; $display("FAIL mid_xor_word: got valid %b data %h expected valid 1 data 601ec313", m_valid, m_data);
      end
      sz = pt_log.size();
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if (m_valid !== 1'b0 || m_data !== 32'd0 || m_last !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_out: got valid %b data %h last %b expected 0 0 0", m_valid, m_data, m_last);
      end
      n_vec++; if (busy !== 1'b0 || core_plaintext !== 128'd0 || blk_count !== 32'd0 || core_start !== 1'b0) begin
         n_fail++; $display("FAIL async_rst_state: got busy %b pt %h blk %0d cs %b expected all 0", busy, core_plaintext, blk_count, core_start);
      end
      repeat (4) @(negedge clk);
      n_vec++; if (m_valid !== 1'b0 || pt_log.size() !== sz) begin
         n_fail++; $display("FAIL async_rst_hold: got valid %b new core_starts %0d expected 0 0", m_valid, pt_log.size() - sz);
      end
      rst_n = 1'b1;
      m_ready = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cfg_nonce = '0; cfg_ctr_init = '0; start = 1'b0; abort = 1'b0;
      s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1; core_ready_en = 1'b1;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_start_ignored;
      test_one_block;
      test_two_blocks;
      test_backpressure;
      test_wrap;
      test_abort;
      test_slast_and_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_ctr_engine.md
AES_CTR_ENGINE -- requirements
Module: aes_ctr_engine

Interface
REQ-001 SHALL have parameter CTR_W, default 32: width of the incrementing counter field, which is the low bits of the 128-bit counter block.
REQ-002 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, async active-low reset); one clock domain; reset is asynchronous and active-low.
REQ-003 SHALL have these control ports:
- cfg_nonce, in, 128-CTR_W: upper counter-block bits.
- cfg_ctr_init, in, CTR_W: initial counter value.
- start, in, 1: one-cycle pulse that begins a stream.
- abort, in, 1: terminates the current stream.
REQ-004 SHALL have these input-stream ports:
- s_data, in, 32: input word.
- s_valid, in, 1: input word valid.
- s_last, in, 1: final input word.
- s_ready, out, 1: engine accepts the word.
REQ-005 SHALL have these output-stream ports:
- m_data, out, 32: s_data XOR keystream word.
- m_valid, out, 1: output word valid.
- m_last, out, 1: final output word.
- m_ready, in, 1: consumer accepts the word.
REQ-006 SHALL have these AES core ports:
- core_plaintext, out, 128: counter block.
- core_start, out, 1: one-cycle encrypt strobe.
- core_ready, in, 1: key loaded and idle.
- core_done, in, 1: one-cycle completion pulse.
- core_ciphertext, in, 128: keystream block.
REQ-007 SHALL have these status ports:
- busy, out, 1: state is not IDLE.
- ctr_wrap, out, 1: sticky counter-exhaustion flag.
- blk_count, out, 32: keystream blocks consumed in the current stream.

Function
REQ-008 SHALL implement states IDLE, GEN, WAIT and XOR.
REQ-009 IDLE: on start with core_ready=1, SHALL load ctr = cfg_ctr_init, latch cfg_nonce, clear blk_count and ctr_wrap, and go to GEN; start with core_ready=0 SHALL be ignored.
REQ-010 GEN: SHALL drive core_start=1 for exactly one cycle, with core_plaintext = {nonce, ctr} stable from GEN until core_done, then go to WAIT.
REQ-011 WAIT: on core_done SHALL capture core_ciphertext into the keystream register, clear the word index to 0, and go to XOR; core_done in any other state SHALL be ignored.
REQ-012 XOR: s_ready SHALL equal (!m_valid || m_ready); s_ready SHALL be 0 in every other state.
REQ-013 On s_valid && s_ready, the engine SHALL:
- register m_data = s_data ^ ks_word[idx], where idx0 = bits 127:96 and idx3 = bits 31:0;
- set m_valid = 1 and m_last = s_last;
- increment idx.
REQ-014 m_valid SHALL clear on m_ready when no new word is accepted that cycle; output latency SHALL be 1 cycle; full throughput SHALL be 1 word/cycle within a block.
REQ-015 Accepting the word with idx=3 and s_last=0 SHALL:
- set ctr = ctr+1 mod 2^CTR_W;
- increment blk_count;
- go to GEN.
REQ-016 If ctr = all-ones at the step in REQ-015, the engine SHALL set ctr_wrap=1 and go to IDLE instead of GEN; keystream reuse is forbidden.
REQ-017 Accepting a word with s_last=1 at any idx SHALL increment blk_count and go to IDLE; remaining keystream words SHALL be discarded.
REQ-018 Return to IDLE SHALL zero the keystream register in the same cycle; a pending m_valid word SHALL still complete its handshake.
REQ-019 abort SHALL take priority over every other event in any state: next state IDLE, m_valid=0, keystream zeroed, idx=0, ctr_wrap unchanged.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 A core_done that arrives after an abort SHALL be ignored.
REQ-022 busy SHALL equal (state != IDLE).

Reset
REQ-023 On rst_n low, asynchronously:
- state = IDLE;
- ctr, nonce, keystream, idx, blk_count = 0;
- m_data = 0, m_valid = 0, m_last = 0;
- core_start = 0, core_plaintext = 0;
- ctr_wrap = 0, busy = 0.
REQ-024 Reset mid-stream SHALL discard all state with no further m_valid or core_start.

Structure
REQ-025 Shared package aes_ctr_pkg SHALL hold the state enum (IDLE, GEN, WAIT, XOR), the default CTR_W, and the constant WORDS_PER_BLK=4.
REQ-026 No sub-module; the FSM, counter, keystream register and output register SHALL reside in aes_ctr_engine.
REQ-027 The bench SHALL pair the engine with the existing aes_core through the core_* ports.

Verification
REQ-028 SP800-38A F.5.5 test:
- Stimulus: key 603deb10...0914dff4; nonce f0f1f2f3f4f5f6f7f8f9fafb; ctr_init fcfdfeff; words 6bc1bee2 2e409f96 e93d7e11 7393172a.
- Response: 601ec313 775789a5 b7a7f504 bbf3d228; blk_count=1.
REQ-029 Same setup, 8 words with second block ae2d8a57 1e03ac9c 9eb76fac 45af8e51:
- Response: second output f443e3ca 4d62b59a ca84e990 cacaf5c5.
- core_plaintext low word = fcfdff00 during block 2.
REQ-030 Wrap test: ctr_init ffffffff, 8 words -> 4 outputs, ctr_wrap=1, state IDLE, s_ready stays 0, no second core_start.
REQ-031 Backpressure test: random m_ready (50%) on the REQ-029 vector -> identical output sequence, no word lost or duplicated, m_data stable while m_valid && !m_ready.
REQ-032 Abort test: abort during WAIT, then a late core_done -> m_valid=0, busy=0, keystream=0; a new start then produces correct vectors.
REQ-033 s_last test: s_last on word 1 of block 1 -> m_last on that word, IDLE next cycle, blk_count=1; async reset mid-XOR -> all outputs 0 immediately.
